pipe_stage_reg: RTL

- Parametrised pipeline boundary register; generalises the fixed-field stage latches such as the MEM→WB latch.
- Carries one packed payload of DATA_W bits, using a valid/ready handshake in place of the plain en/clr pair.
- A 2-entry skid buffer gives full throughput with a registered in_ready, so no combinational ready path crosses the stage.
- Synchronous flush supports exception/branch squash; an optional stall counter is provided.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_sat_counter.sv | 36 +++
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline boundary registers: state encoding,
// default widths and the per-stage payload bundle widths.
package pipe_pkg;

  // State is the pair {skid_v, main_v}; 2'b10 is never entered.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  localparam int DATA_W_DEFAULT = 32;
  localparam int PERF_W_DEFAULT = 16;

  localparam int IF_BUNDLE_W  = 64;
  localparam int ID_BUNDLE_W  = 176;
  localparam int EX_BUNDLE_W  = 192;
  localparam int MEM_BUNDLE_W = 200;
  localparam int WB_BUNDLE_W  = 208;

  function automatic logic [1:0] occupancy_of(input logic [1:0] st);
    return {1'b0, st[1]} + {1'b0, st[0]};
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int W = PERF_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline boundary register with a 2-entry skid buffer and registered in_ready.
// Optional stall counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int PERF_W     = PERF_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [PERF_W-1:0] stall_cnt
);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_fire) state_d = ST_BUSY;
      ST_BUSY: begin
        if (in_fire && !out_ready) begin
          state_d = ST_FULL;
        end else if (!in_fire && out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL:  if (out_fire) state_d = ST_BUSY;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // Payload moves only on the listed transitions, so idle cycles never toggle the data flops.
  always_comb begin
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      ST_EMPTY: if (in_fire) main_data_d = in_data;
      ST_BUSY: begin
        if (in_fire) begin
          if (out_ready) begin
            main_data_d = in_data;
          end else begin
            skid_data_d = in_data;
          end
        end
      end
      ST_FULL:  if (out_fire) main_data_d = skid_data_q;
      default:  ;
    endcase
    if (flush) begin
      main_data_d = CLEAR_DATA ? '0 : main_data_q;
      skid_data_d = CLEAR_DATA ? '0 : skid_data_q;
    end
  end

  // NOTE: payload storage is reset only when CLEAR_DATA asks for it; otherwise the valid bits alone guard it.
  generate
    if (CLEAR_DATA) begin : g_data_clr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          main_data_q <= '0;
          skid_data_q <= '0;
        end else begin
          main_data_q <= main_data_d;
          skid_data_q <= skid_data_d;
        end
      end
    end else begin : g_data_keep
      always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
      end
    end
  endgenerate

  // in_ready decodes straight from the skid_v flop, so no ready path crosses the stage.
  always_comb begin
    out_valid = state_q[0];
    in_ready  = ~state_q[1];
    occupancy = occupancy_of(state_q);
  end

  assign out_data = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;

  assign stall_inc = out_valid & ~out_ready & ~flush;

  pipe_sat_counter #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule
